// File: rtl/ee354_move_arbiter.sv
// ee354_move_arbiter: synchronises and debounces the four direction buttons and
// hands the 2048 game FSM exactly one valid/ready move command per physical press.
module ee354_move_arbiter #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3,
   parameter int MOVES_W         = 16
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               BtnU,
   input  logic               BtnD,
   input  logic               BtnL,
   input  logic               BtnR,
   input  logic               game_active,
   input  logic               move_ready,
   input  logic               move_done,
   input  logic               count_clr,
   output logic               move_valid,
   output logic [1:0]         move_dir,
   output logic               busy,
   output logic [MOVES_W-1:0] move_count
);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      DEBOUNCE     = 3'd1,
      ISSUE        = 3'd2,
      WAIT_DONE    = 3'd3,
      WAIT_RELEASE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]   CntLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
   localparam logic [MOVES_W-1:0] CountMax = '1;
   localparam logic [MOVES_W-1:0] CountOne = MOVES_W'(1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         dirR;
   logic [3:0]         btnMeta;
   logic [3:0]         btnS;
   logic               acceptS;

   // Button vectors are packed {U, D, L, R}; the first set bit from the top wins.
   function automatic logic [1:0] pickDir(input logic [3:0] b);
      logic [1:0] d;
      if (b[3]) begin
         d = 2'b00;
      end else if (b[2]) begin
         d = 2'b01;
      end else if (b[1]) begin
         d = 2'b10;
      end else begin
         d = 2'b11;
      end
      return d;
   endfunction

   function automatic logic btnOf(input logic [3:0] b, input logic [1:0] d);
      logic v;
      case (d)
         2'b00:   v = b[3];
         2'b01:   v = b[2];
         2'b10:   v = b[1];
         default: v = b[0];
      endcase
      return v;
   endfunction

   assign busy    = (state != IDLE);
   assign acceptS = (state == ISSUE) && move_valid && move_ready;

   // Two-flop synchroniser for the asynchronous button pins.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         btnMeta <= 4'b0000;
         btnS    <= 4'b0000;
      end else begin
         btnMeta <= {BtnU, BtnD, BtnL, BtnR};
         btnS    <= btnMeta;
      end
   end

   // Move FSM: debounce the captured button, offer the move, then wait for done and release.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         dirR       <= 2'b00;
         move_valid <= 1'b0;
         move_dir   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (game_active && (btnS != 4'b0000)) begin
                  dirR  <= pickDir(btnS);
                  cnt   <= '0;
                  state <= DEBOUNCE;
               end else begin
                  state <= IDLE;
               end
            end
            DEBOUNCE: begin
               if (!btnOf(btnS, dirR)) begin
                  state <= IDLE;
               end else if (!game_active) begin
                  cnt   <= '0;
                  state <= WAIT_RELEASE;
               end else if (cnt == CntLast) begin
                  move_valid <= 1'b1;
                  move_dir   <= dirR;
                  state      <= ISSUE;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            ISSUE: begin
               // An accepted handshake takes precedence over game_active falling.
               if (move_ready) begin
                  move_valid <= 1'b0;
                  cnt        <= '0;
                  state      <= move_done ? WAIT_RELEASE : WAIT_DONE;
               end else if (!game_active) begin
                  move_valid <= 1'b0;
                  cnt        <= '0;
                  state      <= WAIT_RELEASE;
               end else begin
                  state <= ISSUE;
               end
            end
            WAIT_DONE: begin
               if (move_done) begin
                  cnt   <= '0;
                  state <= WAIT_RELEASE;
               end else begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_RELEASE: begin
               if (btnS != 4'b0000) begin
                  cnt <= '0;
               end else if (cnt == CntLast) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            default: begin
               move_valid <= 1'b0;
               cnt        <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Accepted-move counter: saturates, and a clear beats a same-cycle increment.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         move_count <= '0;
      end else if (count_clr) begin
         move_count <= '0;
      end else if (acceptS && (move_count != CountMax)) begin
         move_count <= move_count + CountOne;
      end else begin
         move_count <= move_count;
      end
   end

endmodule

// File: tb/tb_ee354_move_arbiter.sv
// Self-checking bench for ee354_move_arbiter: directed scenarios plus a randomized
// run compared cycle-by-cycle against a behavioural model of the press/move rules.
module tb_ee354_move_arbiter;

   localparam int DB = 4;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
   logic        game_active = 1'b1;
   logic        move_ready = 1'b0;
   logic        move_done = 1'b0;
   logic        count_clr = 1'b0;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        busy;
   logic [15:0] move_count;

   int checks = 0;
   int errors = 0;

   ee354_move_arbiter #(.DEBOUNCE_CYCLES(DB), .CNT_W(3), .MOVES_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
      .game_active(game_active), .move_ready(move_ready), .move_done(move_done),
      .count_clr(count_clr), .move_valid(move_valid), .move_dir(move_dir),
      .busy(busy), .move_count(move_count)
   );

   always #5 Clk = ~Clk;

   // Behavioural model: buttons seen two edges late; phases follow the press life cycle.
   typedef enum int {M_IDLE, M_PRESS, M_OFFER, M_AWAIT, M_QUIET} mphase_t;
   logic [3:0] hist0, hist1;
   mphase_t    ph;
   int         held, quiet, mCount;
   logic [1:0] mDir;
   bit         mValid;

   function automatic int firstPressed(input logic [3:0] b);
      for (int d = 0; d < 4; d++) if (b[3-d]) return d;
      return 0;
   endfunction

   task automatic modelReset();
      hist0 = 4'b0000; hist1 = 4'b0000; ph = M_IDLE;
      held = 0; quiet = 0; mCount = 0; mDir = 2'b00; mValid = 1'b0;
   endtask

   task automatic modelStep();
      logic [3:0] seen;
      bit accept;
      seen  = hist1;
      hist1 = hist0;
      hist0 = {BtnU, BtnD, BtnL, BtnR};
      accept = (ph == M_OFFER) && move_ready;
      case (ph)
         M_IDLE:  if (game_active && seen != 4'b0000) begin
                     mDir = 2'(firstPressed(seen)); held = 1; ph = M_PRESS;
                  end
         M_PRESS: if (!seen[3-mDir]) ph = M_IDLE;
                  else if (!game_active) begin ph = M_QUIET; quiet = 0; end
                  else begin held++; if (held == DB + 1) ph = M_OFFER; end
         M_OFFER: if (move_ready) begin ph = move_done ? M_QUIET : M_AWAIT; quiet = 0; end
                  else if (!game_active) begin ph = M_QUIET; quiet = 0; end
         M_AWAIT: if (move_done) begin ph = M_QUIET; quiet = 0; end
         default: if (seen != 4'b0000) quiet = 0;
                  else begin quiet++; if (quiet == DB) ph = M_IDLE; end
      endcase
      if (count_clr) mCount = 0;
      else if (accept && mCount < 65535) mCount++;
      mValid = (ph == M_OFFER);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic clearInputs();
      BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
      game_active = 1'b1; move_ready = 1'b0; move_done = 1'b0; count_clr = 1'b0;
   endtask

   task automatic settle();
      clearInputs();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      ticks(10);
   endtask

   task automatic waitValid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = move_valid;
      end
   endtask

   task automatic test_reset();
      clearInputs();
      Reset_n = 1'b0;
      ticks(3);
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", move_valid); end
      checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b want 00", move_dir); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", move_count); end
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_press();
      int nValid = 0, first = 0;
      clearInputs();
      move_ready = 1'b1;
      BtnU = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (move_valid === 1'b1) begin
            nValid++;
            if (first == 0) first = i;
            checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL single_dir: got %b want 00", move_dir); end
         end
      end
      checks++; if (nValid != 1) begin errors++; $display("FAIL single_valid_len: got %0d want 1", nValid); end
      checks++; if (first != 7) begin errors++; $display("FAIL single_latency: got %0d want 7", first); end
      checks++; if (move_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", move_count); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait: got %b want 1", busy); end
      settle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
   endtask

   task automatic test_glitch();
      int nValid = 0;
      bit sawBusy = 1'b0;
      clearInputs();
      move_ready = 1'b1;
      BtnL = 1'b1;
      ticks(2);
      BtnL = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (move_valid === 1'b1) nValid++;
         if (busy === 1'b1) sawBusy = 1'b1;
      end
      checks++; if (nValid != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", nValid); end
      checks++; if (sawBusy !== 1'b1) begin errors++; $display("FAIL glitch_capture: got %b want 1", sawBusy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy); end
      checks++; if (move_count !== 16'd1) begin errors++; $display("FAIL glitch_count: got %0d want 1", move_count); end
   endtask

   task automatic test_priority();
      int nValid = 0;
      clearInputs();
      move_ready = 1'b1;
      BtnD = 1'b1; BtnR = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         move_done = (i == 20);
         tick();
         if (move_valid === 1'b1) begin
            nValid++;
            checks++; if (move_dir !== 2'b01) begin errors++; $display("FAIL prio_dir: got %b want 01", move_dir); end
         end
      end
      clearInputs();
      ticks(12);
      checks++; if (nValid != 1) begin errors++; $display("FAIL prio_one_move: got %0d want 1", nValid); end
      checks++; if (move_count !== 16'd2) begin errors++; $display("FAIL prio_count: got %0d want 2", move_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", busy); end
   endtask

   task automatic test_ready_stall();
      bit seen;
      clearInputs();
      BtnL = 1'b1;
      waitValid(seen);
      checks++; if (!seen) begin errors++; $display("FAIL stall_wait: move_valid=0 after 20 cycles, want 1"); end
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++; if (move_valid !== 1'b1 || move_dir !== 2'b10) begin
            errors++; $display("FAIL stall_hold: valid=%b dir=%b want 1/10", move_valid, move_dir);
         end
      end
      checks++; if (move_count !== 16'd2) begin errors++; $display("FAIL stall_count_pre: got %0d want 2", move_count); end
      move_ready = 1'b1;
      tick();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b want 0", move_valid); end
      checks++; if (move_count !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", move_count); end
      settle();
      checks++; if (move_count !== 16'd3) begin errors++; $display("FAIL stall_count_post: got %0d want 3", move_count); end
   endtask

   task automatic test_game_inactive();
      bit seen, sawBusy = 1'b0;
      int nValid = 0;
      clearInputs();
      BtnR = 1'b1;
      waitValid(seen);
      checks++; if (!seen || move_dir !== 2'b11) begin
         errors++; $display("FAIL inactive_offer: valid=%b dir=%b want 1/11", seen, move_dir);
      end
      game_active = 1'b0;
      tick();
      checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL inactive_drop: got %b want 0", move_valid); end
      checks++; if (move_count !== 16'd3) begin errors++; $display("FAIL inactive_count: got %0d want 3", move_count); end
      BtnR = 1'b0;
      ticks(10);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inactive_release: got %b want 0", busy); end
      BtnU = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (move_valid === 1'b1) nValid++;
         if (busy === 1'b1) sawBusy = 1'b1;
      end
      checks++; if (nValid != 0 || sawBusy) begin
         errors++; $display("FAIL inactive_block: valids=%0d busy=%b want 0/0", nValid, sawBusy);
      end
      game_active = 1'b1;
      waitValid(seen);
      checks++; if (!seen || move_dir !== 2'b00) begin
         errors++; $display("FAIL inactive_resume: valid=%b dir=%b want 1/00", seen, move_dir);
      end
      move_ready = 1'b1;
      tick();
      checks++; if (move_count !== 16'd4) begin errors++; $display("FAIL inactive_count2: got %0d want 4", move_count); end
      settle();
   endtask

   task automatic test_async_reset();
      clearInputs();
      move_ready = 1'b1;
      BtnD = 1'b1;
      ticks(9);
      checks++; if (busy !== 1'b1 || move_count !== 16'd5 || move_dir !== 2'b01) begin
         errors++; $display("FAIL areset_pre: busy=%b count=%0d dir=%b want 1/5/01", busy, move_count, move_dir);
      end
      #2;
      Reset_n = 1'b0;
      #1;
      checks++; if (move_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL areset_ctl: valid=%b busy=%b want 0/0", move_valid, busy);
      end
      checks++; if (move_count !== 16'd0 || move_dir !== 2'b00) begin
         errors++; $display("FAIL areset_data: count=%0d dir=%b want 0/00", move_count, move_dir);
      end
      clearInputs();
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_count_clr();
      bit seen;
      clearInputs();
      BtnU = 1'b1;
      waitValid(seen);
      move_ready = 1'b1;
      tick();
      checks++; if (move_count !== 16'd1) begin errors++; $display("FAIL clr_first: got %0d want 1", move_count); end
      settle();
      BtnL = 1'b1;
      waitValid(seen);
      checks++; if (!seen) begin errors++; $display("FAIL clr_wait: move_valid=0 after 20 cycles, want 1"); end
      move_ready = 1'b1;
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      checks++; if (move_count !== 16'd0 || move_valid !== 1'b0) begin
         errors++; $display("FAIL clr_wins: count=%0d valid=%b want 0/0", move_count, move_valid);
      end
      settle();
   endtask

   task automatic test_random();
      logic [3:0] b = 4'b0000;
      int shown = 0;
      clearInputs();
      Reset_n = 1'b0;
      tick();
      modelReset();
      Reset_n = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
         {BtnU, BtnD, BtnL, BtnR} = b;
         game_active = ($urandom_range(0, 19) != 0);
         move_ready  = ($urandom_range(0, 2) == 0);
         move_done   = ($urandom_range(0, 4) == 0);
         count_clr   = ($urandom_range(0, 99) == 0);
         @(posedge Clk);
         modelStep();
         #1;
         checks++;
         if (move_valid !== mValid || busy !== (ph != M_IDLE) || move_count !== 16'(mCount) ||
             (mValid && move_dir !== mDir)) begin
            errors++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random cyc %0d: valid=%b busy=%b count=%0d dir=%b want %b/%b/%0d/%b",
                        cyc, move_valid, busy, move_count, move_dir, mValid, (ph != M_IDLE), mCount, mDir);
            end
         end
      end
      clearInputs();
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_priority();
      test_ready_stall();
      test_game_inactive();
      test_async_reset();
      test_count_clr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
